// File: rtl/t06_game_fsm_ctrl.sv
// Snake game sequencer: INIT/RUN/UPDATE/PAUSE/OVER with an on-chip game tick,
// a pause button and a watchdog on the display UPDATE handshake.
module t06_game_fsm_ctrl #(
  parameter int BASE_PERIOD = 1_000_000,
  parameter int TICK_W      = 24,
  parameter int SPD_W       = 3,
  parameter int UPD_TIMEOUT = 4096,
  parameter int TO_W        = $clog2(UPD_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             mode_pb,
  input  logic             pause_pb,
  input  logic             cmd_done,
  input  logic             diff,
  input  logic             GameOver,
  input  logic [SPD_W-1:0] speed_sel,
  output logic             init_cycle,
  output logic             enable_loop,
  output logic             en_update,
  output logic             sync_reset,
  output logic             paused,
  output logic             game_tick,
  output logic             fault,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_RUN    = 3'd1,
    S_UPDATE = 3'd2,
    S_PAUSE  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [TICK_W-1:0] BASE_P  = TICK_W'(BASE_PERIOD);
  localparam logic [TO_W-1:0]   WD_LAST = TO_W'(UPD_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_mode_sync;
  logic [2:0]          r_pause_sync;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [TICK_W-1:0]   r_period;
  logic [TO_W-1:0]     r_wd;
  logic                r_fault;
  logic                w_mode_edge;
  logic                w_pause_edge;
  logic [TICK_W-1:0]   w_period_shift;
  logic [TICK_W-1:0]   w_period_ld;
  logic [TICK_W-1:0]   w_tick_last;
  logic                w_wd_fire;

  // Buttons arrive pre-debounced; bit 0 is the first sampling flop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode_sync  <= '0;
      r_pause_sync <= '0;
    end else begin
      r_mode_sync  <= {r_mode_sync[1:0], mode_pb};
      r_pause_sync <= {r_pause_sync[1:0], pause_pb};
    end
  end

  assign w_mode_edge    = r_mode_sync[1] & ~r_mode_sync[2];
  assign w_pause_edge   = r_pause_sync[1] & ~r_pause_sync[2];
  assign w_period_shift = BASE_P >> speed_sel;
  assign w_period_ld    = (w_period_shift == '0) ? TICK_W'(1) : w_period_shift;
  assign w_tick_last    = r_period - TICK_W'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // UPDATE handshake: en_update stays high until cmd_done (level) acknowledges.
  always_comb begin
    w_next      = r_state;
    init_cycle  = 1'b0;
    enable_loop = 1'b0;
    en_update   = 1'b0;
    sync_reset  = 1'b0;
    paused      = 1'b0;
    game_tick   = 1'b0;
    w_wd_fire   = 1'b0;
    case (r_state)
      S_INIT: begin
        init_cycle = ~cmd_done;
        if (cmd_done) w_next = S_RUN;
      end
      S_RUN: begin
        game_tick   = (r_tick_cnt == w_tick_last);
        enable_loop = game_tick & ~diff & ~GameOver;
        if (diff)              w_next = S_UPDATE;
        else if (GameOver)     w_next = S_OVER;
        else if (w_pause_edge) w_next = S_PAUSE;
      end
      S_UPDATE: begin
        en_update = ~(cmd_done | GameOver);
        if (cmd_done)          w_next = S_RUN;
        else if (GameOver)     w_next = S_OVER;
        else if (r_wd == WD_LAST) begin
          w_next    = S_OVER;
          w_wd_fire = 1'b1;
        end
      end
      S_PAUSE: begin
        paused = 1'b1;
        if (w_mode_edge)       w_next = S_INIT;
        else if (w_pause_edge) w_next = S_RUN;
      end
      S_OVER: begin
        sync_reset = ~w_mode_edge;
        if (w_mode_edge) w_next = S_INIT;
      end
      default: w_next = S_INIT;
    endcase
  end

  // Tick counter only advances in RUN, so UPDATE/PAUSE time never counts.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tick_cnt <= '0;
      r_period   <= '0;
    end else if (r_state == S_INIT) begin
      r_tick_cnt <= '0;
      r_period   <= w_period_ld;
    end else if (r_state == S_RUN) begin
      r_tick_cnt <= game_tick ? '0 : r_tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wd    <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == S_UPDATE && w_next == S_UPDATE) r_wd <= r_wd + TO_W'(1);
      else                                           r_wd <= '0;
      if (w_wd_fire)                               r_fault <= 1'b1;
      else if (r_state == S_OVER && w_mode_edge)   r_fault <= 1'b0;
    end
  end

  assign fault     = r_fault;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_t06_game_fsm_ctrl.sv
// Directed bench for t06_game_fsm_ctrl: ticks, UPDATE handshake, watchdog,
// pause, button edges and asynchronous reset.
module tb_t06_game_fsm_ctrl;

  localparam int BP = 16;
  localparam int TW = 24;
  localparam int SW = 3;
  localparam int UT = 8;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_UPD   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          mode_pb, pause_pb, cmd_done, diff, GameOver;
  logic [SW-1:0] speed_sel;
  logic          init_cycle, enable_loop, en_update, sync_reset, paused, game_tick, fault;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  t06_game_fsm_ctrl #(
    .BASE_PERIOD(BP), .TICK_W(TW), .SPD_W(SW), .UPD_TIMEOUT(UT)
  ) dut (
    .clk(clk), .nrst(nrst), .mode_pb(mode_pb), .pause_pb(pause_pb),
    .cmd_done(cmd_done), .diff(diff), .GameOver(GameOver), .speed_sel(speed_sel),
    .init_cycle(init_cycle), .enable_loop(enable_loop), .en_update(en_update),
    .sync_reset(sync_reset), .paused(paused), .game_tick(game_tick), .fault(fault),
    .dbg_state(dbg_state)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    mode_pb = 0; pause_pb = 0; cmd_done = 0; diff = 0; GameOver = 0; speed_sel = 3'd2;
    nrst = 1'b1; #1; nrst = 1'b0; #2;
    n_cmp++; if (dbg_state !== ST_INIT) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_INIT); end
    n_cmp++; if (init_cycle !== 1'b1) begin n_err++; $display("FAIL reset_init_cycle: got %b want 1", init_cycle); end
    n_cmp++; if ({enable_loop, en_update, sync_reset, paused, game_tick, fault} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 000000", {enable_loop, en_update, sync_reset, paused, game_tick, fault}); end
    @(negedge clk); nrst = 1'b1;
    cyc();
    n_cmp++; if (init_cycle !== 1'b1) begin n_err++; $display("FAIL init_hold: got %b want 1", init_cycle); end
    cmd_done = 1; settle();
    n_cmp++; if (init_cycle !== 1'b0) begin n_err++; $display("FAIL init_cmd_done: got %b want 0", init_cycle); end
    cyc(); cmd_done = 0;
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL init_to_run: got %0d want %0d", dbg_state, ST_RUN); end
    exp_cnt = 0;
  endtask

  task automatic test_tick_rate();
    logic exp_tick;
    settle();
    for (int i = 0; i < 12; i++) begin
      exp_tick = (exp_cnt == 3);
      n_cmp++; if (game_tick !== exp_tick) begin n_err++; $display("FAIL tick4_c%0d: got %b want %b", i, game_tick, exp_tick); end
      n_cmp++; if (enable_loop !== exp_tick) begin n_err++; $display("FAIL loop4_c%0d: got %b want %b", i, enable_loop, exp_tick); end
      exp_cnt = exp_tick ? 0 : exp_cnt + 1;
      cyc();
    end
  endtask

  task automatic test_update_handshake();
    diff = 1; settle();
    n_cmp++; if (enable_loop !== 1'b0) begin n_err++; $display("FAIL upd_diff_loop: got %b want 0", enable_loop); end
    cyc(); diff = 0; exp_cnt = 1; settle();
    n_cmp++; if (dbg_state !== ST_UPD) begin n_err++; $display("FAIL upd_enter: got %0d want %0d", dbg_state, ST_UPD); end
    n_cmp++; if (en_update !== 1'b1) begin n_err++; $display("FAIL upd_en_c1: got %b want 1", en_update); end
    for (int c = 2; c <= 7; c++) begin
      cyc();
      n_cmp++; if (en_update !== 1'b1 || dbg_state !== ST_UPD) begin
        n_err++; $display("FAIL upd_wait_c%0d: en=%b st=%0d want en=1 st=%0d", c, en_update, dbg_state, ST_UPD); end
    end
    cyc();
    cmd_done = 1; settle();
    n_cmp++; if (en_update !== 1'b0) begin n_err++; $display("FAIL upd_ack_en: got %b want 0", en_update); end
    cyc(); cmd_done = 0;
    n_cmp++; if (dbg_state !== ST_RUN || fault !== 1'b0) begin
      n_err++; $display("FAIL upd_last_cycle_ack: st=%0d fault=%b want st=%0d fault=0", dbg_state, fault, ST_RUN); end
  endtask

  task automatic test_tick_diff();
    settle();
    n_cmp++; if (game_tick !== 1'b0) begin n_err++; $display("FAIL phase_cnt1: got %b want 0", game_tick); end
    cyc();
    n_cmp++; if (game_tick !== 1'b0) begin n_err++; $display("FAIL phase_cnt2: got %b want 0", game_tick); end
    cyc();
    diff = 1; settle();
    n_cmp++; if (game_tick !== 1'b1) begin n_err++; $display("FAIL tick_diff_tick: got %b want 1", game_tick); end
    n_cmp++; if (enable_loop !== 1'b0) begin n_err++; $display("FAIL tick_diff_loop: got %b want 0", enable_loop); end
    cyc(); diff = 0; exp_cnt = 0;
  endtask

  task automatic test_watchdog();
    pause_pb = 1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) pause_pb = 0;
      settle();
      n_cmp++; if (dbg_state !== ST_UPD || en_update !== 1'b1 || fault !== 1'b0) begin
        n_err++; $display("FAIL wd_c%0d: st=%0d en=%b fault=%b want st=%0d en=1 fault=0", c, dbg_state, en_update, fault, ST_UPD); end
      cyc();
    end
    n_cmp++; if (dbg_state !== ST_OVER) begin n_err++; $display("FAIL wd_over: got %0d want %0d", dbg_state, ST_OVER); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL wd_fault: got %b want 1", fault); end
    n_cmp++; if (sync_reset !== 1'b1 || en_update !== 1'b0) begin
      n_err++; $display("FAIL wd_over_outs: sync=%b en=%b want sync=1 en=0", sync_reset, en_update); end
  endtask

  task automatic test_over_pause_ignored();
    pause_pb = 1; cyc(); pause_pb = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (dbg_state !== ST_OVER) begin n_err++; $display("FAIL over_pause_c%0d: got %0d want %0d", i, dbg_state, ST_OVER); end
    end
  endtask

  task automatic test_mode_held();
    speed_sel = 3'd7;
    mode_pb = 1; settle();
    n_cmp++; if (sync_reset !== 1'b1) begin n_err++; $display("FAIL mode_c0_sync: got %b want 1", sync_reset); end
    cyc();
    n_cmp++; if (sync_reset !== 1'b1 || dbg_state !== ST_OVER) begin
      n_err++; $display("FAIL mode_c1: sync=%b st=%0d want sync=1 st=%0d", sync_reset, dbg_state, ST_OVER); end
    cyc();
    n_cmp++; if (sync_reset !== 1'b0 || fault !== 1'b1) begin
      n_err++; $display("FAIL mode_edge_cycle: sync=%b fault=%b want sync=0 fault=1", sync_reset, fault); end
    cyc();
    n_cmp++; if (dbg_state !== ST_INIT || fault !== 1'b0 || init_cycle !== 1'b1) begin
      n_err++; $display("FAIL mode_to_init: st=%0d fault=%b init=%b want st=%0d fault=0 init=1", dbg_state, fault, init_cycle, ST_INIT); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if (dbg_state !== ST_INIT) begin n_err++; $display("FAIL mode_held_c%0d: got %0d want %0d", i, dbg_state, ST_INIT); end
    end
    mode_pb = 0; cyc();
  endtask

  task automatic test_speed7();
    cmd_done = 1; cyc(); cmd_done = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (game_tick !== 1'b1 || enable_loop !== 1'b1) begin
        n_err++; $display("FAIL speed7_c%0d: tick=%b loop=%b want 1 1", i, game_tick, enable_loop); end
      cyc();
    end
    GameOver = 1; settle();
    n_cmp++; if (enable_loop !== 1'b0 || game_tick !== 1'b1) begin
      n_err++; $display("FAIL speed7_gameover: loop=%b tick=%b want 0 1", enable_loop, game_tick); end
    cyc(); GameOver = 0;
    n_cmp++; if (dbg_state !== ST_OVER || sync_reset !== 1'b1 || fault !== 1'b0) begin
      n_err++; $display("FAIL gameover_over: st=%0d sync=%b fault=%b want st=%0d sync=1 fault=0", dbg_state, sync_reset, fault, ST_OVER); end
    speed_sel = 3'd2;
    mode_pb = 1; cyc(); mode_pb = 0; cyc(); cyc();
    n_cmp++; if (dbg_state !== ST_INIT) begin n_err++; $display("FAIL mode_pulse_init: got %0d want %0d", dbg_state, ST_INIT); end
  endtask

  task automatic test_pause();
    cmd_done = 1; pause_pb = 1; cyc();
    cmd_done = 0; pause_pb = 0; settle();
    n_cmp++; if (dbg_state !== ST_RUN || game_tick !== 1'b0) begin
      n_err++; $display("FAIL pause_pre_cnt0: st=%0d tick=%b want st=%0d tick=0", dbg_state, game_tick, ST_RUN); end
    cyc();
    n_cmp++; if (dbg_state !== ST_RUN || game_tick !== 1'b0) begin
      n_err++; $display("FAIL pause_pre_cnt1: st=%0d tick=%b want st=%0d tick=0", dbg_state, game_tick, ST_RUN); end
    cyc();
    n_cmp++; if (dbg_state !== ST_PAUSE || paused !== 1'b1) begin
      n_err++; $display("FAIL pause_enter: st=%0d paused=%b want st=%0d paused=1", dbg_state, paused, ST_PAUSE); end
    GameOver = 1; diff = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (dbg_state !== ST_PAUSE || {game_tick, enable_loop, en_update, sync_reset, paused} !== 5'b00001) begin
        n_err++; $display("FAIL pause_hold_c%0d: st=%0d outs=%b want st=%0d outs=00001", i, dbg_state,
          {game_tick, enable_loop, en_update, sync_reset, paused}, ST_PAUSE); end
      cyc();
    end
    GameOver = 0; diff = 0;
    pause_pb = 1; cyc(); pause_pb = 0; cyc();
    n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL resume_edge_cycle: got %b want 1", paused); end
    cyc();
    n_cmp++; if (dbg_state !== ST_RUN || paused !== 1'b0 || game_tick !== 1'b0) begin
      n_err++; $display("FAIL resume_cnt2: st=%0d paused=%b tick=%b want st=%0d 0 0", dbg_state, paused, game_tick, ST_RUN); end
    cyc();
    n_cmp++; if (game_tick !== 1'b1 || enable_loop !== 1'b1) begin
      n_err++; $display("FAIL resume_cnt3_tick: tick=%b loop=%b want 1 1", game_tick, enable_loop); end
  endtask

  task automatic test_reset_in_pause();
    pause_pb = 1; cyc(); pause_pb = 0; cyc(); cyc();
    n_cmp++; if (dbg_state !== ST_PAUSE) begin n_err++; $display("FAIL pause_again: got %0d want %0d", dbg_state, ST_PAUSE); end
    #2; nrst = 1'b0; #1;
    n_cmp++; if (dbg_state !== ST_INIT || paused !== 1'b0 || init_cycle !== 1'b1 || fault !== 1'b0) begin
      n_err++; $display("FAIL async_reset_pause: st=%0d paused=%b init=%b fault=%b want st=%0d 0 1 0",
        dbg_state, paused, init_cycle, fault, ST_INIT); end
    @(negedge clk); nrst = 1'b1; cyc();
    n_cmp++; if (dbg_state !== ST_INIT) begin n_err++; $display("FAIL after_reset: got %0d want %0d", dbg_state, ST_INIT); end
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_update_handshake();
    test_tick_diff();
    test_watchdog();
    test_over_pause_ignored();
    test_mode_held();
    test_speed7();
    test_pause();
    test_reset_in_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
